// File: rtl/dmem_mmio_if.sv
// Core data-port and transmit-sink signals of the dmem_mmio stage.
// The core and sink side drives the master modport; dmem_mmio takes the slave modport.
interface dmem_mmio_if;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    // out_valid/out_ready: a word transfers on each rising edge where both are high;
    // out_data holds the head word and stays stable while out_valid & !out_ready.
    modport master (
        output we, a, wd, out_ready,
        input  rd, out_data, out_valid
    );

    modport slave (
        input  we, a, wd, out_ready,
        output rd, out_data, out_valid
    );
endinterface

// File: rtl/dmem_mmio.sv
// Data-memory stage: word RAM, free-running timer with a sticky compare flag, and a
// transmit FIFO drained over valid/ready. Loads are combinational; stores commit on the edge.
module dmem_mmio #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    dmem_mmio_if.slave  bus
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   r_ram  [RAM_WORDS];
    logic [31:0]   r_fifo [FIFO_DEPTH];
    logic [31:0]   r_timer;
    logic [31:0]   r_cmp;
    logic          r_match;
    logic          r_ovf;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_wptr;
    logic [CW-1:0] r_count;

    logic [29:0]   w_word;
    logic [AW-1:0] w_ram_idx;
    logic [1:0]    w_unused_bits;
    logic          w_sel_ram, w_sel_timer, w_sel_cmp, w_sel_status, w_sel_tx;
    logic          w_empty, w_full, w_push, w_pop, w_push_ok;

    assign w_word        = bus.a[31:2];
    assign w_ram_idx     = bus.a[AW+1:2];
    assign w_unused_bits = bus.a[1:0];

    assign w_sel_ram    = (w_word < 30'(RAM_WORDS));
    assign w_sel_timer  = (w_word == 30'h40);
    assign w_sel_cmp    = (w_word == 30'h41);
    assign w_sel_status = (w_word == 30'h42);
    assign w_sel_tx     = (w_word == 30'h43);

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_pop     = !w_empty && bus.out_ready;
    assign w_push    = bus.we && w_sel_tx;
    // A pop on the same edge frees the slot, so a full FIFO can still take the push.
    assign w_push_ok = w_push && (!w_full || w_pop);

    assign bus.out_valid = !w_empty;
    assign bus.out_data  = r_fifo[r_rptr];

    always_ff @(posedge clk) begin
        if (bus.we && w_sel_ram) begin
            r_ram[w_ram_idx] <= bus.wd;
        end
        if (w_push_ok) begin
            r_fifo[r_wptr] <= bus.wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
            r_cmp   <= 32'hFFFF_FFFF;
            r_match <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_timer <= (bus.we && w_sel_timer) ? bus.wd : r_timer + 32'd1;
            if (bus.we && w_sel_cmp) begin
                r_cmp <= bus.wd;
            end
            // Set beats clear when both land on the same edge.
            if (r_timer == r_cmp) begin
                r_match <= 1'b1;
            end else if (bus.we && w_sel_status && bus.wd[2]) begin
                r_match <= 1'b0;
            end
            if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end else if (bus.we && w_sel_status && bus.wd[3]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push_ok) begin
                r_wptr <= r_wptr + PW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        bus.rd = '0;
        if (w_sel_ram) begin
            bus.rd = r_ram[w_ram_idx];
        end else if (w_sel_timer) begin
            bus.rd = r_timer;
        end else if (w_sel_cmp) begin
            bus.rd = r_cmp;
        end else if (w_sel_status) begin
            bus.rd = {28'b0, r_ovf, r_match, w_full, w_empty};
        end else if (w_sel_tx) begin
            bus.rd = {{(32 - CW){1'b0}}, r_count};
        end
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed stores/loads with literal expectations, plus a
// behavioural model of the address map checked against the DUT every cycle.
module tb_dmem_mmio;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    dmem_mmio_if bus ();

    dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_ram [64];
    bit          m_ram_v [64];
    logic [31:0] m_timer = 32'd0;
    logic [31:0] m_cmp   = 32'hFFFF_FFFF;
    bit          m_match = 1'b0;
    bit          m_ovf   = 1'b0;
    logic [31:0] exp_q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_timer = 32'd0;
            m_cmp   = 32'hFFFF_FFFF;
            m_match = 1'b0;
            m_ovf   = 1'b0;
            exp_q.delete();
        end else begin
            automatic int          word = int'(bus.a >> 2);
            automatic bit          hit  = (m_timer == m_cmp);
            automatic bit          pop  = (exp_q.size() > 0) && bus.out_ready;
            automatic bit          push = bus.we && (word == 'h43);
            if (bus.we && word < 64) begin
                m_ram[word]   = bus.wd;
                m_ram_v[word] = 1'b1;
            end
            if (bus.we && word == 'h40) m_timer = bus.wd;
            else                        m_timer = m_timer + 32'd1;
            if (bus.we && word == 'h41) m_cmp = bus.wd;
            if (bus.we && word == 'h42) begin
                if (bus.wd[2]) m_match = 1'b0;
                if (bus.wd[3]) m_ovf   = 1'b0;
            end
            if (hit) m_match = 1'b1;
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(bus.wd);
                else                      m_ovf = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        automatic int          word = int'(bus.a >> 2);
        automatic bit          known = 1'b1;
        automatic logic [31:0] exp_rd = 32'd0;
        automatic int          cnt = exp_q.size();
        if (word < 64) begin
            known  = m_ram_v[word];
            exp_rd = m_ram[word];
        end else if (word == 'h40) exp_rd = m_timer;
        else if (word == 'h41)     exp_rd = m_cmp;
        else if (word == 'h42)     exp_rd = {28'd0, m_ovf, m_match, cnt == DEPTH, cnt == 0};
        else if (word == 'h43)     exp_rd = 32'(cnt);
        if (known) check("model_rd", bus.rd, exp_rd);
        check("model_out_valid", {31'd0, bus.out_valid}, {31'd0, cnt != 0});
        if (cnt != 0) check("model_out_data", bus.out_data, exp_q[0]);
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        bus.we = 1'b1;
        bus.a  = addr;
        bus.wd = data;
        step();
        bus.we = 1'b0;
    endtask

    task automatic load_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus.a = addr;
        #1;
        check(name, bus.rd, exp);
    endtask

    task automatic drain_check(input string name, input logic [31:0] exp);
        #1;
        check({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check(name, bus.out_data, exp);
        step();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [31:0] first_fill [4];
        first_fill = '{32'hA, 32'hB, 32'hC, 32'hD};

        bus.we = 1'b0;
        bus.a = 32'h0;
        bus.wd = 32'h0;
        bus.out_ready = 1'b0;
        step();
        step();
        load_check("reset_timer", 32'h100, 32'h0);
        load_check("reset_cmp", 32'h104, 32'hFFFF_FFFF);
        load_check("reset_status", 32'h108, 32'h1);
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        step();
        reset = 1'b0;

        load_check("timer_cyc0", 32'h100, 32'd0);
        step();
        load_check("timer_cyc1", 32'h100, 32'd1);
        store(32'h100, 32'hFFFF_FFFE);
        load_check("timer_load", 32'h100, 32'hFFFF_FFFE);
        step();
        load_check("timer_max", 32'h100, 32'hFFFF_FFFF);
        step();
        load_check("timer_wrap", 32'h100, 32'h0);

        store(32'd100, 32'd25);
        store(32'd96, 32'd7);
        store(32'h0, 32'h55);
        load_check("ram_100", 32'd100, 32'd25);
        load_check("ram_96", 32'd96, 32'd7);
        load_check("unmapped_rd", 32'h200, 32'h0);
        store(32'h200, 32'h1234);
        load_check("unmapped_after_store", 32'h200, 32'h0);
        load_check("ram_0_no_alias", 32'h0, 32'h55);
        load_check("ram_100_kept", 32'd100, 32'd25);

        store(32'h100, 32'd100);
        store(32'h104, 32'd10);
        store(32'h108, 32'hC);
        store(32'h100, 32'd0);
        for (int k = 0; k <= 10; k++) begin
            load_check("status_before_match", 32'h108, 32'h1);
            step();
        end
        load_check("status_match", 32'h108, 32'h5);
        store(32'h108, 32'h4);
        load_check("status_match_cleared", 32'h108, 32'h1);

        store(32'h100, 32'd9);
        step();
        store(32'h108, 32'h4);
        load_check("match_set_wins", 32'h108, 32'h5);
        store(32'h108, 32'h4);
        load_check("match_clear_again", 32'h108, 32'h1);

        for (int i = 0; i < 5; i++) store(32'h10C, 32'hA + 32'(i));
        load_check("fifo_count_full", 32'h10C, 32'd4);
        load_check("status_full_ovf", 32'h108, 32'hA);
        check("head_word", bus.out_data, 32'hA);
        bus.a = 32'h0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) drain_check("drain_order", first_fill[i]);
        #1;
        check("drained_valid", {31'd0, bus.out_valid}, 32'd0);

        bus.out_ready = 1'b0;
        store(32'h108, 32'h8);
        load_check("ovf_cleared", 32'h108, 32'h1);
        for (int i = 1; i <= 4; i++) store(32'h10C, 32'(i));
        load_check("refill_status", 32'h108, 32'h2);
        bus.out_ready = 1'b1;
        store(32'h10C, 32'hF);
        load_check("push_pop_count", 32'h10C, 32'd4);
        load_check("push_pop_no_ovf", 32'h108, 32'h2);
        bus.a = 32'h0;
        drain_check("pp_drain", 32'h2);
        drain_check("pp_drain", 32'h3);
        drain_check("pp_drain", 32'h4);
        drain_check("pp_drain_last", 32'hF);
        #1;
        check("pp_drained_valid", {31'd0, bus.out_valid}, 32'd0);

        store(32'h10C, 32'h77);
        check("empty_push_valid", {31'd0, bus.out_valid}, 32'd1);
        check("empty_push_data", bus.out_data, 32'h77);
        load_check("empty_push_count", 32'h10C, 32'd1);
        step();
        check("empty_push_popped", {31'd0, bus.out_valid}, 32'd0);

        bus.out_ready = 1'b0;
        store(32'h10C, 32'h11);
        store(32'h10C, 32'h22);
        store(32'h10C, 32'h33);
        bus.out_ready = 1'b1;
        step();
        load_check("mid_drain_count", 32'h10C, 32'd2);
        reset = 1'b1;
        #1;
        check("reset_mid_valid", {31'd0, bus.out_valid}, 32'd0);
        load_check("reset_mid_count", 32'h10C, 32'd0);
        load_check("reset_mid_ram", 32'd100, 32'd25);
        load_check("reset_mid_timer", 32'h100, 32'd0);
        step();
        reset = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-memory stage with memory-mapped peripherals, sitting directly downstream of the single-cycle core's data port. It takes the core's store enable, address and store data, and returns load data combinationally in the same cycle. It contains a 64-word data RAM, a free-running cycle timer with a compare flag, and a transmit FIFO. The FIFO drains to an external sink over a valid/ready handshake.

## Interface
Parameters:
- RAM_WORDS, 64, data RAM depth in 32-bit words; power of two, at most 64.
- FIFO_DEPTH, 4, transmit FIFO depth in words; power of two, at least 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state except RAM contents.
- we  in  1  store enable (core MemWrite).
- a  in  32  byte address (core ALUResult); a[1:0] ignored, accesses are word-aligned.
- wd  in  32  store data.
- rd  out  32  load data, combinational from a and current state.
- out_data  out  32  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  sink accepts head word this cycle.

## Operation
Address map, decoded on a[31:2]; all other addresses read 0 and ignore stores:
- 0x000–0x0FC: RAM word a[7:2]. Store writes on the clock edge; load is asynchronous. RAM is not reset and is undefined until written.
- 0x100 TIMER: read returns the counter. A store loads wd. Otherwise the counter increments by 1 each cycle and wraps 0xFFFFFFFF→0.
- 0x104 CMP: read/write compare register.
- 0x108 STATUS: read returns {28'b0, ovf, match, full, empty}.
  - Bit 0 empty (count==0), bit 1 full (count==FIFO_DEPTH).
  - Bit 2 match: sticky; set on an edge where TIMER==CMP before the edge.
  - Bit 3 ovf: sticky; set when a push is dropped.
  - A store to STATUS clears the match and ovf bits selected by wd[2] and wd[3].
  - If a set and a clear occur on the same edge, the set wins.
- 0x10C TXDATA: a store pushes wd. A read returns the FIFO occupancy count, zero-extended.

FIFO:
- Circular buffer with read pointer, write pointer and a count register of width log2(FIFO_DEPTH)+1.
- Pop when out_valid & out_ready.
- A push is accepted when count<FIFO_DEPTH, or when a pop occurs on the same edge. A push while full with no pop is dropped and sets ovf.
- Simultaneous push and pop: both pointers advance and count is unchanged. On an empty FIFO, a push with out_ready=1 does not pop in that cycle, because out_valid=0.
- out_data = entry at the read pointer. It is held stable while out_valid & !out_ready.

## Timing
- Load latency 0: rd is valid in the same cycle as a, so the single-cycle core reads in-cycle. A load of TIMER returns the pre-edge value.
- Store effects are visible to loads in the cycle after the edge.
- TIMER store: the stored value is visible next cycle and increments from the following edge. A store takes priority over increment.
- match sets on the edge that ends the cycle in which TIMER==CMP; STATUS[2] reads 1 from the next cycle.
- A pushed word appears on out_data/out_valid the cycle after the push edge. The FIFO has no fall-through.
- Reset values (asynchronous): TIMER=0, CMP=0xFFFFFFFF, match=0, ovf=0, FIFO pointers and count=0.
- Outputs under reset: out_valid=0 and rd follows the address map. out_data is don't-care while out_valid=0.
- Reset mid-transfer discards FIFO contents and leaves RAM intact.

## Test plan
- Store 25 to 100, store 7 to 96, then load 100 → rd=25. Load 96 → 7. Load 0x200 → 0, and a store there changes nothing.
- Deassert reset and read TIMER in cycles 0 and 1 → 0 then 1. Store 0xFFFFFFFE to TIMER → reads 0xFFFFFFFE, 0xFFFFFFFF, then 0 on subsequent cycles.
- Store CMP=10 after reset → STATUS reads 0x1 until TIMER passes 10, then 0x5. Store 0x4 to STATUS → 0x1.
- Hold out_ready=0 and push 0xA,0xB,0xC,0xD,0xE → count=4, STATUS=0xA (full and ovf set), out_data=0xA. Raise out_ready → sink receives A,B,C,D in order, then out_valid=0.
- Hold the FIFO full with out_ready=1 and push 0xF on the same edge as a pop → count stays 4, ovf unchanged, and 0xF is delivered last.
- Push 3 words, then assert reset mid-drain → out_valid=0 immediately, count reads 0, RAM word at 100 still reads 25.
